// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: two-stage multiply-accumulate.
// Stage 1 registers the extended product a*b with cin/clr/valid.
// Stage 2 adds it to (or loads it into) the accumulator, with
// carry/overflow detection and optional saturation.
module mac_pipe_acc #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [ACC_W-1:0]  out,
    output logic              out_valid,
    output logic              cout,
    output logic              ovf
);

    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
        $error("mac_pipe_acc: ACC_W must be at least 2*DATA_W");
    end

    // Operands are extended to ACC_W before multiplying; since the true
    // product fits in 2*DATA_W <= ACC_W bits, the low ACC_W bits of the
    // wide product are exactly the sign/zero-extended product.
    logic             a_ext_bit;
    logic             b_ext_bit;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod_next;

    // Operand extension and product
    always_comb begin
        a_ext_bit = (SIGNED != 0) ? a[DATA_W-1] : 1'b0;
        b_ext_bit = (SIGNED != 0) ? b[DATA_W-1] : 1'b0;
        a_ext     = {{(ACC_W - DATA_W){a_ext_bit}}, a};
        b_ext     = {{(ACC_W - DATA_W){b_ext_bit}}, b};
        prod_next = a_ext * b_ext;
    end

    logic [ACC_W-1:0] prod_s1;
    logic             cin_s1;
    logic             clr_s1;
    logic             valid_s1;

    // Stage 1: capture product and control on accepted items
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_s1  <= '0;
            cin_s1   <= 1'b0;
            clr_s1   <= 1'b0;
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= in_valid;
            if (in_valid) begin
                prod_s1 <= prod_next;
                cin_s1  <= cin;
                clr_s1  <= clr;
            end
        end
    end

    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic             flag;
    logic [ACC_W-1:0] sat_val;
    logic [ACC_W-1:0] acc_next;

    // Stage 2 datapath: add, detect overflow, optionally clamp
    always_comb begin
        base = clr_s1 ? '0 : out;
        sum  = {1'b0, base} + {1'b0, prod_s1} + {{ACC_W{1'b0}}, cin_s1};
        if (SIGNED != 0) begin
            flag = (base[ACC_W-1] == prod_s1[ACC_W-1]) &&
                   (sum[ACC_W-1] != base[ACC_W-1]);
            // Overflow direction follows the common sign of the addends
            sat_val = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            flag    = sum[ACC_W];
            sat_val = '1;
        end
        acc_next = (SATURATE != 0 && flag) ? sat_val : sum[ACC_W-1:0];
    end

    // Stage 2: accumulator and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= valid_s1;
            if (valid_s1) begin
                out  <= acc_next;
                cout <= flag;
                ovf  <= clr_s1 ? flag : (ovf | flag);
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Testbench for mac_pipe_acc: directed vectors against four
// parameterisations sharing one input bus.
module tb_mac_pipe_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;

    logic [23:0] out_d;  logic ov_d;  logic co_d;  logic of_d;
    logic [15:0] out_w;  logic ov_w;  logic co_w;  logic of_w;
    logic [15:0] out_s;  logic ov_s;  logic co_s;  logic of_s;
    logic [23:0] out_g;  logic ov_g;  logic co_g;  logic of_g;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_pipe_acc u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr), .a(a), .b(b), .cin(cin),
        .out(out_d), .out_valid(ov_d), .cout(co_d), .ovf(of_d)
    );

    mac_pipe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr), .a(a), .b(b), .cin(cin),
        .out(out_w), .out_valid(ov_w), .cout(co_w), .ovf(of_w)
    );

    mac_pipe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr), .a(a), .b(b), .cin(cin),
        .out(out_s), .out_valid(ov_s), .cout(co_s), .ovf(of_s)
    );

    mac_pipe_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(0)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr), .a(a), .b(b), .cin(cin),
        .out(out_g), .out_valid(ov_g), .cout(co_g), .ovf(of_g)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic iv, input logic c, input logic [7:0] va,
                        input logic [7:0] vb, input logic ci);
        in_valid = iv; clr = c; a = va; b = vb; cin = ci;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic        clr;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic        exp_valid;
        logic [23:0] exp_out;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Expected values after each edge reflect the item applied one record earlier
        vecs[0]  = '{1'b1, 1'b1, 8'd15, 8'd10, 1'b0, 1'b0, 24'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'd20, 8'd25, 1'b0, 1'b1, 24'd150};
        vecs[2]  = '{1'b1, 1'b0, 8'd50, 8'd30, 1'b0, 1'b1, 24'd650};
        vecs[3]  = '{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b1, 24'd2150};
        vecs[4]  = '{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0, 24'd2150};
        vecs[5]  = '{1'b1, 1'b1, 8'd15, 8'd10, 1'b0, 1'b0, 24'd2150};
        vecs[6]  = '{1'b1, 1'b0, 8'd20, 8'd25, 1'b0, 1'b1, 24'd150};
        vecs[7]  = '{1'b0, 1'b1, 8'd99, 8'd99, 1'b1, 1'b1, 24'd650};
        vecs[8]  = '{1'b1, 1'b0, 8'd50, 8'd30, 1'b0, 1'b0, 24'd650};
        vecs[9]  = '{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b1, 24'd2150};
        vecs[10] = '{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0, 24'd2150};

        // Reset held for two edges with toggling stimulus
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, i[0], 8'd200 + 8'(i), 8'd77, 1'b1);
            chk("rst_out", 32'(out_d), 32'd0);
            chk("rst_valid", 32'(ov_d), 32'd0);
            chk("rst_cout", 32'(co_d), 32'd0);
            chk("rst_ovf", 32'(of_d), 32'd0);
        end
        in_valid = 1'b0;
        rst = 1'b0;

        // Accumulate stream and bubble stream on the default instance
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].iv, vecs[i].clr, vecs[i].a, vecs[i].b, vecs[i].cin);
            chk($sformatf("vec%0d_valid", i), 32'(ov_d), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_out", i), 32'(out_d), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_cout", i), 32'(co_d), 32'd0);
            chk($sformatf("vec%0d_ovf", i), 32'(of_d), 32'd0);
        end

        // Overflow at ACC_W=16: wrap vs saturate, sticky ovf, cleared by clr
        step(1'b1, 1'b1, 8'd255, 8'd255, 1'b0);
        step(1'b1, 1'b0, 8'd255, 8'd255, 1'b0);
        chk("ovf1_w_out", 32'(out_w), 32'd65025);
        chk("ovf1_w_cout", 32'(co_w), 32'd0);
        chk("ovf1_s_out", 32'(out_s), 32'd65025);
        step(1'b1, 1'b0, 8'd1, 8'd1, 1'b0);
        chk("ovf2_w_out", 32'(out_w), 32'd64514);
        chk("ovf2_w_cout", 32'(co_w), 32'd1);
        chk("ovf2_w_ovf", 32'(of_w), 32'd1);
        chk("ovf2_s_out", 32'(out_s), 32'd65535);
        chk("ovf2_s_cout", 32'(co_s), 32'd1);
        step(1'b1, 1'b1, 8'd1, 8'd1, 1'b0);
        chk("ovf3_w_out", 32'(out_w), 32'd64515);
        chk("ovf3_w_cout", 32'(co_w), 32'd0);
        chk("ovf3_w_sticky", 32'(of_w), 32'd1);
        chk("ovf3_s_out", 32'(out_s), 32'd65535);
        chk("ovf3_s_cout", 32'(co_s), 32'd1);
        step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("ovf4_w_out", 32'(out_w), 32'd1);
        chk("ovf4_w_ovf", 32'(of_w), 32'd0);
        chk("ovf4_s_out", 32'(out_s), 32'd1);
        chk("ovf4_s_ovf", 32'(of_s), 32'd0);

        // Signed: -3*5 then +4*4+cin
        step(1'b1, 1'b1, 8'hFD, 8'd5, 1'b0);
        step(1'b1, 1'b0, 8'd4, 8'd4, 1'b1);
        chk("sgn1_out", 32'(out_g), 32'h00FF_FFF1);
        chk("sgn1_valid", 32'(ov_g), 32'd1);
        step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("sgn2_out", 32'(out_g), 32'h0000_0002);
        chk("sgn2_cout", 32'(co_g), 32'd0);

        // Reset mid-stream: prime accumulator, put two items in flight, reset asynchronously
        step(1'b1, 1'b1, 8'd10, 8'd10, 1'b0);
        step(1'b1, 1'b0, 8'd5, 8'd5, 1'b0);
        chk("mid_pre_out", 32'(out_d), 32'd100);
        in_valid = 1'b1; clr = 1'b0; a = 8'd6; b = 8'd6;
        rst = 1'b1;
        #1;
        chk("mid_async_out", 32'(out_d), 32'd0);
        chk("mid_async_valid", 32'(ov_d), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_hold_valid", 32'(ov_d), 32'd0);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'd3, 8'd3, 1'b0);
        chk("mid_flush_valid", 32'(ov_d), 32'd0);
        step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("mid_after_valid", 32'(ov_d), 32'd1);
        chk("mid_after_out", 32'(out_d), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
